// File: rtl/datapath_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between an instruction source and the sequencer.
// The slave modport is the sequencer side; the master modport is the fetch/driver side.
interface datapath_ctrl_fsm_if;
  logic        start;
  logic [15:0] instr;
  logic        w;
  logic        illegal;
  logic [2:0]  readnum;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic [15:0] datapath_in;

  modport slave (
    input  start, instr,
    output w, illegal, readnum, loada, loadb, shift, asel, bsel, ALUop,
           loadc, loads, writenum, write, vsel, datapath_in
  );

  modport master (
    output start, instr,
    input  w, illegal, readnum, loada, loadb, shift, asel, bsel, ALUop,
           loadc, loads, writenum, write, vsel, datapath_in
  );
endinterface

// File: rtl/datapath_ctrl_fsm.sv
// Instruction sequencer for the MOV/ADD/CMP/AND/MVN subset: latches one instruction and
// steps the datapath controls one stage per clock. Outputs are Moore (state + IR).
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  WAIT     | idle, w=1, accepts start and latches instr into IR
//  DECODE   | classify IR; unsupported encodings pulse illegal and return
//  WR_IMM   | write sign-extended imm8 into Rn
//  LOAD_A   | read Rn into A
//  LOAD_B   | read Rm into B
//  EXEC     | run ALU; CMP updates status only, others load C
//  WR_REG   | write C back into Rd
module datapath_ctrl_fsm (
  input  logic                clk,
  input  logic                reset_n,
  datapath_ctrl_fsm_if.slave  ctrl
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_LOAD_A = 3'd3,
    S_LOAD_B = 3'd4,
    S_EXEC   = 3'd5,
    S_WR_REG = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic       is_movi, is_movr, is_mvn, is_add, is_cmp, is_and;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
  assign is_add  = (opcode == 3'b101) && (op == 2'b00);
  assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
  assign is_and  = (opcode == 3'b101) && (op == 2'b10);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    ctrl.w           = 1'b0;
    ctrl.illegal     = 1'b0;
    ctrl.readnum     = 3'd0;
    ctrl.loada       = 1'b0;
    ctrl.loadb       = 1'b0;
    ctrl.shift       = 2'b00;
    ctrl.asel        = 1'b0;
    ctrl.bsel        = 1'b0;
    ctrl.ALUop       = 2'b00;
    ctrl.loadc       = 1'b0;
    ctrl.loads       = 1'b0;
    ctrl.writenum    = 3'd0;
    ctrl.write       = 1'b0;
    ctrl.vsel        = 1'b0;
    ctrl.datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

    case (state_q)
      S_WAIT: begin
        ctrl.w = 1'b1;
        if (ctrl.start) begin
          ir_d    = ctrl.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_movi)                     state_d = S_WR_IMM;
        else if (is_movr || is_mvn)      state_d = S_LOAD_B;
        else if (is_add || is_cmp || is_and) state_d = S_LOAD_A;
        else begin
          ctrl.illegal = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WR_IMM: begin
        ctrl.writenum = rn;
        ctrl.vsel     = 1'b1;
        ctrl.write    = 1'b1;
        state_d       = S_WAIT;
      end
      S_LOAD_A: begin
        ctrl.readnum = rn;
        ctrl.loada   = 1'b1;
        state_d      = S_LOAD_B;
      end
      S_LOAD_B: begin
        ctrl.readnum = rm;
        ctrl.loadb   = 1'b1;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        ctrl.shift = sh;
        // MOV-reg and MVN pass B through the ALU with A forced to zero
        ctrl.asel  = is_movr || is_mvn;
        if (is_cmp)      ctrl.ALUop = 2'b01;
        else if (is_and) ctrl.ALUop = 2'b10;
        else if (is_mvn) ctrl.ALUop = 2'b11;
        else             ctrl.ALUop = 2'b00;
        if (is_cmp) begin
          ctrl.loads = 1'b1;
          state_d    = S_WAIT;
        end else begin
          ctrl.loadc = 1'b1;
          state_d    = S_WR_REG;
        end
      end
      S_WR_REG: begin
        ctrl.writenum = rd;
        ctrl.write    = 1'b1;
        state_d       = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Self-checking bench for datapath_ctrl_fsm: a per-cycle expected-output queue is filled from
// an instruction-level model when an instruction is issued and drained one entry per clock.
module tb_datapath_ctrl_fsm;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  aluop;
    logic        loadc;
    logic        loads;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic [15:0] dpin;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  datapath_ctrl_fsm_if dp_if ();

  datapath_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (dp_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t observed();
    exp_t o;
    o.w        = dp_if.w;
    o.illegal  = dp_if.illegal;
    o.readnum  = dp_if.readnum;
    o.loada    = dp_if.loada;
    o.loadb    = dp_if.loadb;
    o.shift    = dp_if.shift;
    o.asel     = dp_if.asel;
    o.bsel     = dp_if.bsel;
    o.aluop    = dp_if.ALUop;
    o.loadc    = dp_if.loadc;
    o.loads    = dp_if.loads;
    o.writenum = dp_if.writenum;
    o.write    = dp_if.write;
    o.vsel     = dp_if.vsel;
    o.dpin     = dp_if.datapath_in;
    return o;
  endfunction

  function automatic exp_t base(input logic [15:0] ins);
    exp_t e;
    e      = '0;
    e.dpin = {{8{ins[7]}}, ins[7:0]};
    return e;
  endfunction

  task automatic check(input string tag, input exp_t obs, input exp_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected cycle-by-cycle outputs from DECODE onward, optionally ending with the WAIT cycle.
  task automatic push_model(input logic [15:0] ins, input bit with_wait);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    bit movi, movr, mvn, add, cmp, andi;
    exp_t e;
    opc = ins[15:13]; op = ins[12:11];
    rn = ins[10:8]; rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    mvn  = (opc == 3'b101) && (op == 2'b11);
    add  = (opc == 3'b101) && (op == 2'b00);
    cmp  = (opc == 3'b101) && (op == 2'b01);
    andi = (opc == 3'b101) && (op == 2'b10);
    e = base(ins);
    e.illegal = !(movi || movr || mvn || add || cmp || andi);
    q.push_back(e);
    if (movi) begin
      e = base(ins); e.writenum = rn; e.vsel = 1'b1; e.write = 1'b1;
      q.push_back(e);
    end
    if (add || cmp || andi) begin
      e = base(ins); e.readnum = rn; e.loada = 1'b1;
      q.push_back(e);
    end
    if (movr || mvn || add || cmp || andi) begin
      e = base(ins); e.readnum = rm; e.loadb = 1'b1;
      q.push_back(e);
      e = base(ins); e.shift = sh; e.asel = movr || mvn;
      e.aluop = cmp ? 2'b01 : andi ? 2'b10 : mvn ? 2'b11 : 2'b00;
      if (cmp) e.loads = 1'b1; else e.loadc = 1'b1;
      q.push_back(e);
      if (!cmp) begin
        e = base(ins); e.writenum = rd; e.write = 1'b1;
        q.push_back(e);
      end
    end
    if (with_wait) begin
      e = base(ins); e.w = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic wait_ready();
    int n;
    exp_t o, e;
    n = 0;
    @(negedge clk);
    while (dp_if.w !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    o = '0; e = '0;
    o.w = dp_if.w; e.w = 1'b1;
    check("ready", o, e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      check(tag, observed(), e);
    end
  endtask

  task automatic issue(input logic [15:0] ins, input string tag);
    wait_ready();
    dp_if.instr = ins;
    dp_if.start = 1'b1;
    push_model(ins, 1'b1);
    @(posedge clk);
    #1;
    dp_if.start = 1'b0;
    dp_if.instr = 16'($urandom);
    drain(tag);
  endtask

  initial begin
    exp_t rst_e, e;
    int n_a;
    logic [2:0] opcs [6];
    logic [1:0] ops  [6];
    opcs = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101};
    ops  = '{2'b10,  2'b00,  2'b11,  2'b00,  2'b01,  2'b10};

    dp_if.start = 1'b0;
    dp_if.instr = 16'hFFFF;
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    rst_e = '0; rst_e.w = 1'b1;
    check("reset", observed(), rst_e);

    // start is ignored in WAIT only when low; idle cycles must not move IR
    @(negedge clk);
    check("idle", observed(), rst_e);

    issue(16'hD107, "mov_imm_pos");
    issue(16'hD0F0, "mov_imm_neg");
    issue(16'hA14A, "add");
    issue(16'hA902, "cmp");
    issue(16'hB3A9, "and");
    issue(16'hC05A, "mov_reg");
    issue(16'hB8F7, "mvn");
    issue(16'hE000, "illegal_e000");
    issue(16'hC8FF, "illegal_110_01");
    issue(16'hD7FF, "mov_imm_r7");

    for (int i = 0; i < 8; i++) begin
      int k;
      k = $urandom_range(0, 5);
      issue({opcs[k], ops[k], 11'($urandom)}, "random");
    end

    // back-to-back: start held high, instr swapped mid-flight must not disturb IR
    wait_ready();
    dp_if.instr = 16'hD285;
    dp_if.start = 1'b1;
    push_model(16'hD285, 1'b1);
    n_a = q.size();
    push_model(16'hA14A, 1'b1);
    @(posedge clk);
    #1 dp_if.instr = 16'hA14A;
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      check("back_to_back", observed(), e);
      if (i == n_a) begin
        dp_if.start = 1'b0;
        dp_if.instr = 16'h0000;
      end
    end

    // reset while ADD sits in EXEC: back to WAIT with IR cleared, no further writes
    wait_ready();
    dp_if.instr = 16'hA14A;
    dp_if.start = 1'b1;
    push_model(16'hA14A, 1'b0);
    void'(q.pop_back());
    @(posedge clk);
    #1 dp_if.start = 1'b0;
    drain("pre_reset");
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_reset", observed(), rst_e);
    end

    issue(16'hD107, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
